// File: rtl/ahb3lite_imem_responder.sv
// AHB3-Lite instruction-fetch responder: loadable instruction table, programmable wait states,
// error responses and an optional fetch log FIFO (enabled by `define IMEM_FETCH_LOG_EN).
module ahb3lite_imem_responder #(
  parameter logic [31:0] BASE_ADDR    = 32'h200,
  parameter int unsigned DEPTH        = 64,
  parameter int unsigned LOG_DEPTH    = 8,
  parameter logic [31:0] DEFAULT_INST = 32'h13
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     HSEL,
  input  logic [31:0]              HADDR,
  input  logic [1:0]               HTRANS,
  input  logic                     HWRITE,
  input  logic [2:0]               HSIZE,
  input  logic                     HREADY,
  output logic [31:0]              HRDATA,
  output logic                     HREADYOUT,
  output logic                     HRESP,
  input  logic                     ld_we,
  input  logic [$clog2(DEPTH)-1:0] ld_idx,
  input  logic [31:0]              ld_data,
  input  logic [3:0]               cfg_wait,
  output logic                     log_valid,
  input  logic                     log_ready,
  output logic [31:0]              log_pc,
  output logic [31:0]              log_inst
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  // 33-bit bounds so the upper limit cannot wrap past 4 GiB.
  localparam logic [32:0] LoAddr = {1'b0, BASE_ADDR};
  localparam logic [32:0] HiAddr = LoAddr + 33'(DEPTH) * 33'd4;

  typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

  state_e            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       imem_q [DEPTH];

  logic        accept, req_err, take, log_can_accept, done;
  logic [32:0] haddr_ext;
  logic [31:0] offset, rd_word;

  assign haddr_ext = {1'b0, HADDR};
  assign offset    = HADDR - BASE_ADDR;
  assign accept    = HSEL & HTRANS[1] & HREADY;
  assign req_err   = HWRITE | (HSIZE != 3'b010) | (HADDR[1:0] != 2'b00) |
                     (haddr_ext < LoAddr) | (haddr_ext >= HiAddr);
  assign rd_word   = imem_q[idx_q];
  assign done      = (state_q == StData) & log_can_accept;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    take    = 1'b0;
    unique case (state_q)
      StIdle: take = accept;
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StData;
      end
      StData: begin
        if (done) begin
          rdata_d = rd_word;
          state_d = StIdle;
          take    = accept;
        end
      end
      StErr1: state_d = StErr2;
      StErr2: begin
        state_d = StIdle;
        take    = accept;
      end
      default: state_d = StIdle;
    endcase
    if (take) begin
      addr_d = HADDR;
      idx_d  = offset[IDX_W+1:2];
      cnt_d  = cfg_wait;
      if (req_err)               state_d = StErr1;
      else if (cfg_wait == 4'd0) state_d = StData;
      else                       state_d = StWait;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // A load and a completing read of the same entry in one cycle returns the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) imem_q[i] <= DEFAULT_INST;
    end else if (ld_we) begin
      imem_q[ld_idx] <= ld_data;
    end
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    unique case (state_q)
      StWait: HREADYOUT = 1'b0;
      StData: HREADYOUT = log_can_accept;
      StErr1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      StErr2: HRESP = 1'b1;
      default: ;
    endcase
  end

  assign HRDATA = (state_q == StData) ? rd_word : rdata_q;

`ifdef IMEM_FETCH_LOG_EN
  localparam int unsigned LW = $clog2(LOG_DEPTH);
  localparam logic [LW:0] LogFull = (LW+1)'(LOG_DEPTH);

  logic [31:0]   fpc_q   [LOG_DEPTH];
  logic [31:0]   finst_q [LOG_DEPTH];
  logic [LW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW:0]   fcnt_q, fcnt_d;
  logic          push, pop;
  logic          unused_bits;

  assign pop            = log_valid & log_ready;
  assign log_can_accept = (fcnt_q != LogFull) | pop;
  assign push           = done;
  assign log_valid      = (fcnt_q != '0);
  assign log_pc         = fpc_q[rptr_q];
  assign log_inst       = finst_q[rptr_q];

  always_comb begin
    wptr_d = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop  ? rptr_q + 1'b1 : rptr_q;
    fcnt_d = fcnt_q + (LW+1)'(push) - (LW+1)'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      fcnt_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      fcnt_q <= fcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fpc_q[wptr_q]   <= addr_q;
      finst_q[wptr_q] <= rd_word;
    end
  end

  assign unused_bits = ^{offset[31:IDX_W+2], offset[1:0], HTRANS[0]};
`else
  logic unused_bits;

  assign log_can_accept = 1'b1;
  assign log_valid      = 1'b0;
  assign log_pc         = '0;
  assign log_inst       = '0;
  assign unused_bits    = ^{offset[31:IDX_W+2], offset[1:0], HTRANS[0], log_ready, addr_q};
`endif

endmodule
